// File: rtl/csla_sub8_pipe.sv
// -----------------------------------------------------------------------------
// csla_sub8_pipe
//
// Two-stage pipelined 8-bit subtractor: diff = (x - y - bin) mod 256.
// It computes x + ~y + ~bin with a square-root carry-select adder using
// 2/3/3 bit grouping:
//   group A bits [1:0]  2-bit CLA fed by the real carry-in, gives c2
//   group B bits [4:2]  3-bit CLA (cin=0) plus BEC-1 (+1) candidate, c2 selects
//   group C bits [7:5]  same as group B, c5 selects
// Stage 1 registers the group A result and all four group B/C candidates.
// Stage 2 registers the resolved sum after the two cascaded muxes.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operands on x/y/bin are valid
//   in_ready   block accepts operands this cycle (combinational from out_ready)
//   x, y       minuend / subtrahend, 8 bits
//   bin        borrow in
//   out_valid  diff/bout/ovf valid
//   out_ready  consumer accepts the result this cycle
//   diff       (x - y - bin) mod 256
//   bout       borrow out, 1 when unsigned x < y + bin
//   ovf        two's complement overflow of x - y - bin
// -----------------------------------------------------------------------------
module csla_sub8_pipe (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       bin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] diff,
    output logic       bout,
    output logic       ovf
);

    // 3-bit carry-lookahead add with carry-in 0; returns {carry, sum}.
    function automatic logic [3:0] cla3(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] g;
        logic [2:0] p;
        logic       c1;
        logic       c2;
        logic       c3;
        g  = a & b;
        p  = a ^ b;
        c1 = g[0];
        c2 = g[1] | (p[1] & g[0]);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]);
        return {c3, p ^ {c2, c1, 1'b0}};
    endfunction

    // Binary-to-excess-1 converter: v + 1 without a carry chain. The 3-bit
    // sum plus carry never exceeds 14, so the increment cannot wrap.
    function automatic logic [3:0] bec4(input logic [3:0] v);
        return {v[3] ^ (v[2] & v[1] & v[0]),
                v[2] ^ (v[1] & v[0]),
                v[1] ^ v[0],
                ~v[0]};
    endfunction

    // ---------------- stage 1 combinational: CLAs and BEC paths -------------
    logic [7:0] w_yn;
    logic       w_cin;
    logic [1:0] w_ga_g;
    logic [1:0] w_ga_p;
    logic       w_ga_c1;
    logic       w_c2;
    logic [1:0] w_ga_sum;
    logic [3:0] w_gb_c0;
    logic [3:0] w_gb_c1;
    logic [3:0] w_gc_c0;
    logic [3:0] w_gc_c1;

    assign w_yn     = ~y;
    assign w_cin    = ~bin;

    assign w_ga_g   = x[1:0] & w_yn[1:0];
    assign w_ga_p   = x[1:0] ^ w_yn[1:0];
    assign w_ga_c1  = w_ga_g[0] | (w_ga_p[0] & w_cin);
    assign w_c2     = w_ga_g[1] | (w_ga_p[1] & w_ga_g[0]) | (w_ga_p[1] & w_ga_p[0] & w_cin);
    assign w_ga_sum = w_ga_p ^ {w_ga_c1, w_cin};

    assign w_gb_c0  = cla3(x[4:2], w_yn[4:2]);
    assign w_gb_c1  = bec4(w_gb_c0);
    assign w_gc_c0  = cla3(x[7:5], w_yn[7:5]);
    assign w_gc_c1  = bec4(w_gc_c0);

    // ---------------- handshake ---------------------------------------------
    logic r_s1_v;
    logic r_s2_v;
    logic w_s1_load;
    logic w_s2_load;

    assign in_ready  = ~r_s1_v | ~r_s2_v | out_ready;
    assign w_s1_load = in_valid & in_ready;
    assign w_s2_load = r_s1_v & (~r_s2_v | out_ready);
    assign out_valid = r_s2_v;

    // ---------------- stage 1 registers --------------------------------------
    logic [1:0] r_s1_lo;
    logic       r_s1_c2;
    logic [3:0] r_s1_gb_c0;
    logic [3:0] r_s1_gb_c1;
    logic [3:0] r_s1_gc_c0;
    logic [3:0] r_s1_gc_c1;
    logic       r_s1_x7;
    logic       r_s1_y7;

    // ---------------- stage 2 combinational: cascaded carry-select muxes ----
    logic [3:0] w_gb_sel;
    logic [3:0] w_gc_sel;
    logic [7:0] w_diff;

    assign w_gb_sel = r_s1_c2     ? r_s1_gb_c1 : r_s1_gb_c0;
    assign w_gc_sel = w_gb_sel[3] ? r_s1_gc_c1 : r_s1_gc_c0;
    assign w_diff   = {w_gc_sel[2:0], w_gb_sel[2:0], r_s1_lo};

    // ---------------- sequential state ---------------------------------------
    // NOTE: data registers are cleared on reset as well as the valid bits, so
    // the outputs read 0 after reset rather than whatever was last computed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v     <= 1'b0;
            r_s2_v     <= 1'b0;
            r_s1_lo    <= '0;
            r_s1_c2    <= 1'b0;
            r_s1_gb_c0 <= '0;
            r_s1_gb_c1 <= '0;
            r_s1_gc_c0 <= '0;
            r_s1_gc_c1 <= '0;
            r_s1_x7    <= 1'b0;
            r_s1_y7    <= 1'b0;
            diff       <= '0;
            bout       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            // Stage 1 valid: set on load, cleared when its content moves on.
            if (w_s1_load)      r_s1_v <= 1'b1;
            else if (w_s2_load) r_s1_v <= 1'b0;

            // Stage 2 valid: set on load, cleared when consumed.
            if (w_s2_load)      r_s2_v <= 1'b1;
            else if (out_ready) r_s2_v <= 1'b0;

            // Data only moves on a load; idle stages hold their contents.
            if (w_s1_load) begin
                r_s1_lo    <= w_ga_sum;
                r_s1_c2    <= w_c2;
                r_s1_gb_c0 <= w_gb_c0;
                r_s1_gb_c1 <= w_gb_c1;
                r_s1_gc_c0 <= w_gc_c0;
                r_s1_gc_c1 <= w_gc_c1;
                r_s1_x7    <= x[7];
                r_s1_y7    <= y[7];
            end

            if (w_s2_load) begin
                diff <= w_diff;
                bout <= ~w_gc_sel[3];
                ovf  <= (r_s1_x7 ^ r_s1_y7) & (w_diff[7] ^ r_s1_x7);
            end
        end
    end

endmodule

// File: tb/tb_csla_sub8_pipe.sv
// -----------------------------------------------------------------------------
// tb_csla_sub8_pipe
//
// Directed and random checks of csla_sub8_pipe. Inputs change 1 ns after each
// rising edge and outputs are sampled 2 ns after it. A queue holds the
// expected results of accepted operands; every output handshake pops it.
// -----------------------------------------------------------------------------
module tb_csla_sub8_pipe;

    typedef struct packed {
        logic [7:0] d;
        logic       b;
        logic       o;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x;
    logic [7:0] y;
    logic       bin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;

    csla_sub8_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t exp_q[$];
    exp_t pend;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference: 9-bit subtraction, borrow is bit 8; overflow from the signs.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] r;
        exp_t       e;
        r   = {1'b0, a} - {1'b0, b} - {8'd0, c};
        e.d = r[7:0];
        e.b = r[8];
        e.o = (a[7] != b[7]) && (r[7] != a[7]);
        return e;
    endfunction

    task automatic set_vec(input logic [7:0] a, input logic [7:0] b, input logic c,
                           input logic [7:0] d, input logic bo, input logic o);
        x        = a;
        y        = b;
        bin      = c;
        pend.d   = d;
        pend.b   = bo;
        pend.o   = o;
        in_valid = 1'b1;
    endtask

    task automatic set_rand();
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        c = 1'($urandom_range(0, 1));
        x = a; y = b; bin = c;
        pend = model(a, b, c);
        in_valid = 1'b1;
    endtask

    // One clock: score the handshakes of this cycle, then cross the edge.
    task automatic cycle(output bit acc);
        exp_t e;
        acc = 1'b0;
        #1;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && exp_q.size() == 0)
                check("spurious_out_valid", out_valid, 0);
            else if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                check("diff", diff, e.d);
                check("bout", bout, e.b);
                check("ovf",  ovf,  e.o);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(pend);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        bit a;
        int k;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            cycle(a);
            k++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        bit       a;
        int       lat;
        int       acc_cnt;
        logic [7:0] held;
        bit       held_ok;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0; bin = 1'b0; pend = '0;
        @(posedge clk);
        #1;

        // ---- reset with in_valid held high ----
        set_vec(8'h12, 8'h34, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle(a);
        cycle(a);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_diff",      diff,      0);
        check("rst_bout",      bout,      0);
        check("rst_ovf",       ovf,       0);
        check("rst_in_ready",  in_ready,  1);
        repeat (3) cycle(a);   // any result here is flagged as spurious

        // ---- basic, with latency measurement ----
        set_vec(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
        cycle(a);
        check("basic_accept", a, 1);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            cycle(a);
            lat++;
        end
        check("latency_edges", lat, 2);
        drain(8);

        set_vec(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        cycle(a);
        drain(8);

        // ---- carry-select corners ----
        set_vec(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        cycle(a);
        set_vec(8'h7F, 8'hFF, 1'b1, 8'h7F, 1'b1, 1'b0);
        cycle(a);
        set_vec(8'h04, 8'h00, 1'b1, 8'h03, 1'b0, 1'b0);
        cycle(a);
        set_vec(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0);
        cycle(a);
        set_vec(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0);
        cycle(a);
        drain(8);

        // ---- back-pressure: 4 operands with out_ready low ----
        out_ready = 1'b0;
        acc_cnt   = 0;
        held_ok   = 1'b0;
        held      = '0;
        for (int c = 0; c < 6; c++) begin
            if (acc_cnt < 4) set_rand();
            if (acc_cnt == 2 && c >= 2) check("bp_in_ready_low", in_ready, 0);
            if (out_valid && held_ok)   check("bp_diff_stable", diff, held);
            if (out_valid && !held_ok) begin
                held    = diff;
                held_ok = 1'b1;
            end
            cycle(a);
            if (a) acc_cnt++;
        end
        check("bp_accepted", acc_cnt, 2);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (acc_cnt < 4) set_rand();
            else in_valid = 1'b0;
            #1;
            check("bp_release_valid", out_valid, 1);
            cycle(a);
            if (a) acc_cnt++;
        end
        check("bp_total", acc_cnt, 4);
        drain(8);

        // ---- full rate: 256 random operands ----
        for (int c = 0; c < 256; c++) begin
            set_rand();
            if (c >= 2) check("fr_out_valid", out_valid, 1);
            check("fr_in_ready", in_ready, 1);
            cycle(a);
        end
        drain(8);

        // ---- mid-operation reset with both stages full ----
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            set_rand();
            cycle(a);
        end
        check("mr_full", in_ready, 0);
        rst = 1'b1;
        cycle(a);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check("mr_out_valid", out_valid, 0);
        check("mr_in_ready",  in_ready,  1);
        for (int c = 0; c < 6; c++) begin
            set_rand();
            cycle(a);
        end
        drain(8);
        repeat (3) cycle(a);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
